// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between ALU and load results, with a destination scoreboard.
// Define WB_ROUND_ROBIN_EN for alternating conflict grants; default is fixed A-over-M.
module regfile_wb_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        m_valid,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    output logic        m_ready,
    input  logic        claim_valid,
    input  logic [4:0]  claim_addr,
    output logic        stall,
    output logic [4:0]  rwd,
    output logic [31:0] wb_data,
    output logic        wb_en,
    output logic [31:0] pending
);

    logic        a_gnt;
    logic        m_gnt;
    logic        hs;
    logic [4:0]  hs_addr;
    logic [31:0] hs_data;
    logic        hs_hit;
    logic        wr;
    logic        claim_set;

    logic [4:0]  rwd_q, rwd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] pending_q, pending_d;

`ifdef WB_ROUND_ROBIN_EN
    // rr_q == 0 favours A on the next conflict
    logic rr_q, rr_d;

    always_comb begin
        a_gnt = 1'b0;
        m_gnt = 1'b0;
        rr_d  = rr_q;
        if (!RST) begin
            if (a_valid && m_valid) begin
                a_gnt = !rr_q;
                m_gnt = rr_q;
                rr_d  = !rr_q;
            end else begin
                a_gnt = a_valid;
                m_gnt = m_valid;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        a_gnt = 1'b0;
        m_gnt = 1'b0;
        if (!RST) begin
            a_gnt = a_valid;
            m_gnt = m_valid && !a_valid;
        end
    end
`endif

    always_comb begin
        hs      = a_gnt || m_gnt;
        hs_addr = 5'd0;
        hs_data = 32'd0;
        unique case (1'b1)
            a_gnt: begin
                hs_addr = a_addr;
                hs_data = a_data;
            end
            m_gnt: begin
                hs_addr = m_addr;
                hs_data = m_data;
            end
            default: begin
                hs_addr = 5'd0;
                hs_data = 32'd0;
            end
        endcase
    end

    // A retiring write to the claimed register frees it in the same cycle
    always_comb begin
        hs_hit    = hs && (hs_addr == claim_addr);
        stall     = !RST && claim_valid && (claim_addr != 5'd0)
                    && pending_q[claim_addr] && !hs_hit;
        claim_set = !RST && claim_valid && (claim_addr != 5'd0) && !stall;
    end

    always_comb begin
        pending_d = pending_q;
        if (hs && (hs_addr != 5'd0)) begin
            pending_d[hs_addr] = 1'b0;
        end
        if (claim_set) begin
            pending_d[claim_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        wr        = hs && (hs_addr != 5'd0);
        rwd_d     = wr ? hs_addr : 5'd0;
        wb_data_d = wr ? hs_data : 32'd0;
        wb_en_d   = wr;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rwd_q     <= 5'd0;
            wb_data_q <= 32'd0;
            wb_en_q   <= 1'b0;
            pending_q <= 32'd0;
        end else begin
            rwd_q     <= rwd_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
            pending_q <= pending_d;
        end
    end

    assign a_ready = a_gnt;
    assign m_ready = m_gnt;
    assign rwd     = rwd_q;
    assign wb_data = wb_data_q;
    assign wb_en   = wb_en_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter (either arbitration build).
module tb_regfile_wb_arbiter;

`ifdef WB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        a_valid, m_valid, claim_valid;
    logic [4:0]  a_addr, m_addr, claim_addr;
    logic [31:0] a_data, m_data;
    logic        a_ready, m_ready, stall, wb_en;
    logic [4:0]  rwd;
    logic [31:0] wb_data, pending;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .stall(stall),
        .rwd(rwd), .wb_data(wb_data), .wb_en(wb_en), .pending(pending)
    );

    typedef struct {
        logic        rst, av, mv, cv;
        logic [4:0]  aa, ma, ca;
        logic [31:0] ad, md;
        logic        ear, emr, est, een;
        logic [4:0]  erwd;
        logic [31:0] ewd, epend;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(
        input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic cv, input logic [4:0] ca,
        input logic ear, input logic emr, input logic est,
        input logic [4:0] erwd, input logic [31:0] ewd, input logic een,
        input logic [31:0] epend);
        vec_t v;
        v.rst = rst; v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md; v.cv = cv; v.ca = ca;
        v.ear = ear; v.emr = emr; v.est = est;
        v.erwd = erwd; v.ewd = ewd; v.een = een; v.epend = epend;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge CLK);
        #1;
        RST = v.rst;
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        m_valid = v.mv; m_addr = v.ma; m_data = v.md;
        claim_valid = v.cv; claim_addr = v.ca;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        m_valid = 0; m_addr = 0; m_data = 0;
        claim_valid = 0; claim_addr = 0;
        repeat (2) @(posedge CLK);

        tv.push_back(mk(1,1,5,32'h1234,1,6,32'h66,1,3, 0,0,0, 0,0,0,0));
        tv.push_back(mk(0,1,5,32'h1234,0,0,0,0,0, 1,0,0, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 5,32'h1234,1,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,1,9,32'hCAFE,0,0, 0,1,0, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 9,32'hCAFE,1,0));
        tv.push_back(mk(0,0,0,0,0,0,0,1,7, 0,0,0, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,1,7, 0,0,1, 0,0,0,32'h80));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,32'h80));
        tv.push_back(mk(0,0,0,0,1,7,32'h77,1,7, 0,1,0, 0,0,0,32'h80));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 7,32'h77,1,32'h80));
        tv.push_back(mk(0,1,7,32'h11,0,0,0,0,0, 1,0,0, 0,0,0,32'h80));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 7,32'h11,1,0));
        tv.push_back(mk(0,1,0,32'hFFFF,0,0,0,1,0, 1,0,0, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0));
        tv.push_back(mk(0,1,3,32'h33,1,4,32'h44,0,0, 1,0,0, 0,0,0,0));
        tv.push_back(mk(0,1,3,32'h33,1,4,32'h44,0,0, !RR,RR,0, 3,32'h33,1,0));
        tv.push_back(mk(0,0,0,0,0,0,0,1,8, 0,0,0,
                        RR ? 5'd4 : 5'd3, RR ? 32'h44 : 32'h33, 1, 0));
        tv.push_back(mk(0,0,0,0,0,0,0,1,9, 0,0,0, 0,0,0,32'h100));
        tv.push_back(mk(0,0,0,0,0,0,0,1,10, 0,0,0, 0,0,0,32'h300));
        tv.push_back(mk(0,0,0,0,0,0,0,1,11, 0,0,0, 0,0,0,32'h700));
        tv.push_back(mk(0,1,12,32'hABCD,0,0,0,1,10, 1,0,1, 0,0,0,32'hF00));
        tv.push_back(mk(1,1,13,32'h1,1,14,32'h2,1,8, 0,0,0, 12,32'hABCD,1,32'hF00));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0));

        foreach (tv[i]) begin
            apply(tv[i]);
            chk("a_ready", i, {31'd0, a_ready}, {31'd0, tv[i].ear});
            chk("m_ready", i, {31'd0, m_ready}, {31'd0, tv[i].emr});
            chk("stall",   i, {31'd0, stall},   {31'd0, tv[i].est});
            chk("rwd",     i, {27'd0, rwd},     {27'd0, tv[i].erwd});
            chk("wb_data", i, wb_data,          tv[i].ewd);
            chk("wb_en",   i, {31'd0, wb_en},   {31'd0, tv[i].een});
            chk("pending", i, pending,          tv[i].epend);
        end

        // Loser M holds its request until A drops away
        apply(mk(0,1,20,32'hA20,1,21,32'hB21,0,0, 0,0,0, 0,0,0,0));
        chk("hold_a_ready", 0, {31'd0, a_ready}, 32'd1);
        chk("hold_m_ready", 0, {31'd0, m_ready}, 32'd0);
        apply(mk(0,0,0,0,1,21,32'hB21,0,0, 0,0,0, 0,0,0,0));
        chk("hold_m_ready", 1, {31'd0, m_ready}, 32'd1);
        chk("hold_a_ready", 1, {31'd0, a_ready}, 32'd0);
        chk("hold_rwd",     1, {27'd0, rwd},     32'd20);
        chk("hold_wb_data", 1, wb_data,          32'hA20);
        apply(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0));
        chk("hold_rwd",     2, {27'd0, rwd},     32'd21);
        chk("hold_wb_data", 2, wb_data,          32'hB21);
        chk("hold_wb_en",   2, {31'd0, wb_en},   32'd1);
        apply(mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0));
        chk("hold_wb_en",   3, {31'd0, wb_en},   32'd0);
        chk("hold_rwd",     3, {27'd0, rwd},     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
